mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Requests use a valid/ready handshake, and at most one transaction is outstanding at a time. The LSU normally has priority; a starvation counter guarantees IFU progress. The block sits between IFU/LSU and the DPI-backed memory model, and it owns request latching, grant sequencing and response routing.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive lost arbitrations after which the IFU wins the next grant (range 1..15).

Ports:
- Clock and reset: one clock, `sys_clk`; reset is `sys_rst`, synchronous and active-high.
- sys_clk  in  1  clock; all state updates on the rising edge
- sys_rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  32  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  32  LSU address
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  store byte mask
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store acknowledged
- lsu_rdata  out  32  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched request fields
- mem_resp_valid  in  1  memory response; one pulse per accepted request, including stores
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: grant a requester if any request is valid; go to ISSUE.
  - ISSUE: hold mem_req_valid; go to WAIT on mem_req_ready.
  - WAIT: on mem_resp_valid, route the response and go to IDLE.
- The ready outputs are combinational. They are high only in IDLE, and only for the granted requester, so at most one is high per cycle.
- Grant rule when both requests are valid: LSU wins unless starve_cnt == STARVE_LIMIT, in which case IFU wins. When only one request is valid, that requester wins.
- starve_cnt (4 bits):
  - +1, saturating at STARVE_LIMIT, when the LSU is granted while ifu_req_valid is high.
  - Cleared when the IFU is granted.
  - Unchanged otherwise.
- On a grant, latch the owner (IFU/LSU) and addr, wen, wdata and wmask. For IFU grants, wen = 0 and wmask = 0.
- The mem_* request fields are driven from the latch and stay stable while mem_req_valid is high.
- Response routing: on mem_resp_valid in WAIT, the next cycle pulses the owner's resp_valid for exactly one cycle.
  - rdata = mem_rdata for loads/fetches; lsu_rdata = 0 for stores.
  - The non-owner's resp_valid stays 0.
- mem_resp_valid outside WAIT is a protocol violation. It is ignored and produces no resp pulse.

## Timing
- Reset: state IDLE, starve_cnt 0, owner IFU, latched fields 0. All outputs are 0, including mem_req_valid and both resp_valid, except the combinational readies, which follow IDLE grant logic from the first post-reset cycle.
- Handshake accepted in cycle N (IDLE) → mem_req_valid high from N+1.
- mem_req_ready in cycle M → state is WAIT at M+1; mem_req_valid is low from M+1.
- mem_resp_valid in cycle K (WAIT) → state is IDLE at K+1, and resp_valid pulses at K+1.
- A new request can be accepted at K+1, in the same cycle as the response pulse.
- Best case, with ready and response both immediate: 3 cycles per transaction, i.e. accept N, issue N+1, resp N+2, pulse N+3 (back-to-back accept at N+3).
- Requester inputs are sampled only at the accepting cycle. Later changes have no effect on the in-flight transaction.
- Reset mid-transaction: return to IDLE and drop the in-flight transaction. No resp pulse is produced, and a late mem_resp_valid is ignored per the rule above.

## Structure
- Shared package `npc_mem_pkg`: the FSM state enum, the owner enum (OWN_IFU, OWN_LSU), and a request struct (wen, addr, wdata, wmask).
- Sub-module `mem_arb_grant` (combinational): takes both req_valid signals, the FSM-is-IDLE flag, starve_cnt and STARVE_LIMIT, and produces one-hot grant/ready.
- The FSM, latches, counter and response registers stay in the top module.

## Test plan
- **IFU only:** ifu_addr = 0x8000_0000, memory ready immediately and responding 1 cycle later with 0x0000_0413.
  - Expect ifu_resp_valid for exactly one cycle, ifu_rdata = 0x0000_0413.
  - Expect lsu_resp_valid never high.
  - Expect accept→pulse = 3 cycles.
- **Simultaneous requests:** IFU and LSU both valid; LSU load at 0x8000_0100.
  - Expect the LSU granted first.
  - Expect the IFU granted at the first IDLE after the LSU response.
  - Expect starve_cnt = 1, then 0.
- **Starvation:** LSU held valid continuously, IFU valid, STARVE_LIMIT = 4.
  - Expect exactly 4 LSU grants, then 1 IFU grant, then the pattern repeats.
- **Store:** addr 0x8000_0200, wdata 0xDEAD_BEEF, wmask 4'b0011, memory ready delayed 3 cycles.
  - Expect mem_* fields stable throughout ISSUE.
  - Expect lsu_resp_valid pulse with lsu_rdata = 0.
- **Reset during WAIT:**
  - Expect state IDLE and no resp pulse.
  - A stray mem_resp_valid one cycle later produces no pulse.
  - The next IFU request completes normally.
- **Back-to-back:** the IFU re-requests in the same cycle its resp pulse appears.
  - Expect acceptance in that cycle and mem_req_valid high the next cycle.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, transaction owner
// and the latched request record presented to the memory port.
package npc_mem_pkg;

   localparam int STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant logic: picks at most one requester while the arbiter
// is idle. The LSU wins contested cycles unless the IFU has been starved.
module mem_arb_grant
   import npc_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    ifu_valid,
   input  logic                    lsu_valid,
   input  logic                    is_idle,
   input  logic [STARVE_CNT_W-1:0] starve_cnt,
   output logic                    grant_ifu,
   output logic                    grant_lsu
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic ifu_wins;

   // One-hot grant: IFU wins when alone or when it has hit the starvation limit
   always_comb begin
      ifu_wins  = ifu_valid && (!lsu_valid || (starve_cnt == LIMIT));
      grant_ifu = is_idle && ifu_wins;
      grant_lsu = is_idle && lsu_valid && !ifu_wins;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between the IFU and the LSU with one
// outstanding transaction at a time. Owns request latching, the
// IDLE/ISSUE/WAIT sequencing, the starvation counter and response routing.
module mem_arbiter
   import npc_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   arb_state_e              state;
   owner_e                  owner;
   mem_req_t                req_q;
   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    grant_ifu;
   logic                    grant_lsu;
   logic                    ifu_resp_q;
   logic                    lsu_resp_q;
   logic [31:0]             ifu_rdata_q;
   logic [31:0]             lsu_rdata_q;

   mem_arb_grant #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_grant (
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .is_idle   (state == ST_IDLE),
      .starve_cnt(starve_cnt),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   assign ifu_req_ready  = grant_ifu;
   assign lsu_req_ready  = grant_lsu;

   assign mem_req_valid  = (state == ST_ISSUE);
   assign mem_wen        = req_q.wen;
   assign mem_addr       = req_q.addr;
   assign mem_wdata      = req_q.wdata;
   assign mem_wmask      = req_q.wmask;

   assign ifu_resp_valid = ifu_resp_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_resp_valid = lsu_resp_q;
   assign lsu_rdata      = lsu_rdata_q;

   // Transaction sequencing: grant in IDLE, hold the request in ISSUE, await data in WAIT
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (grant_ifu || grant_lsu) state <= ST_ISSUE;
            ST_ISSUE: if (mem_req_ready)          state <= ST_WAIT;
            ST_WAIT:  if (mem_resp_valid)         state <= ST_IDLE;
            default:                              state <= ST_IDLE;
         endcase
      end
   end

   // Capture the winner's request on the grant so later input changes cannot disturb it
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         owner <= OWN_IFU;
         req_q <= '0;
      end else if (grant_ifu) begin
         owner       <= OWN_IFU;
         req_q.wen   <= 1'b0;
         req_q.addr  <= ifu_addr;
         req_q.wdata <= '0;
         req_q.wmask <= '0;
      end else if (grant_lsu) begin
         owner       <= OWN_LSU;
         req_q.wen   <= lsu_wen;
         req_q.addr  <= lsu_addr;
         req_q.wdata <= lsu_wdata;
         req_q.wmask <= lsu_wmask;
      end
   end

   // Count LSU wins over a waiting IFU; an IFU grant resets the count
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         starve_cnt <= '0;
      end else if (grant_ifu) begin
         starve_cnt <= '0;
      end else if (grant_lsu && ifu_req_valid && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Route a memory response to its owner as a one-cycle pulse; responses outside WAIT are dropped
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ifu_resp_q  <= 1'b0;
         lsu_resp_q  <= 1'b0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
      end else begin
         ifu_resp_q <= 1'b0;
         lsu_resp_q <= 1'b0;
         if ((state == ST_WAIT) && mem_resp_valid) begin
            if (owner == OWN_IFU) begin
               ifu_resp_q  <= 1'b1;
               ifu_rdata_q <= mem_rdata;
            end else begin
               lsu_resp_q  <= 1'b1;
               lsu_rdata_q <= req_q.wen ? 32'd0 : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   always #5 sys_clk = ~sys_clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Reference model: one outstanding transaction, its latched fields and pending pulses
   bit          m_busy, m_issued, m_own_lsu, m_wen;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wmask;
   int          m_losses;
   bit          m_pulse_ifu, m_pulse_lsu;
   logic [31:0] m_ifu_rdata, m_lsu_rdata;
   int          acc_cycle, prev_acc_cycle, issue_wait;

   // Stimulus controls
   bit          req_random, mem_random, hold_resp, stray_resp, chk_latency, chk_gap;
   bit          mem_fixed_en;
   logic [31:0] mem_fixed_data;
   int          ifu_pend, lsu_pend, ready_delay;
   logic [31:0] ifu_next_addr, lsu_next_addr, lsu_next_wdata;
   logic        lsu_next_wen;
   logic [3:0]  lsu_next_wmask;
   bit          grant_log[$];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance the model over the edge
   task automatic applyStimulus(input bit rst);
      bit idle, ifu_wins, e_gi, e_gl;
      sys_rst = rst;
      if (req_random) begin
         ifu_req_valid = ($urandom_range(0, 9) < 6);
         ifu_addr      = $urandom;
         lsu_req_valid = ($urandom_range(0, 9) < 6);
         lsu_wen       = 1'($urandom_range(0, 1));
         lsu_addr      = $urandom;
         lsu_wdata     = $urandom;
         lsu_wmask     = 4'($urandom);
      end else begin
         ifu_req_valid = (ifu_pend > 0);
         ifu_addr      = ifu_req_valid ? ifu_next_addr : $urandom;
         lsu_req_valid = (lsu_pend > 0);
         lsu_wen       = lsu_req_valid ? lsu_next_wen   : 1'($urandom_range(0, 1));
         lsu_addr      = lsu_req_valid ? lsu_next_addr  : $urandom;
         lsu_wdata     = lsu_req_valid ? lsu_next_wdata : $urandom;
         lsu_wmask     = lsu_req_valid ? lsu_next_wmask : 4'($urandom);
      end
      if (mem_random) begin
         mem_req_ready  = 1'($urandom_range(0, 1));
         mem_resp_valid = ($urandom_range(0, 9) < 4);
      end else begin
         mem_req_ready  = m_busy && !m_issued && (issue_wait >= ready_delay);
         mem_resp_valid = (m_busy && m_issued && !hold_resp) || stray_resp;
      end
      mem_rdata = mem_fixed_en ? mem_fixed_data : $urandom;
      #1;

      idle     = !m_busy;
      ifu_wins = ifu_req_valid && (!lsu_req_valid || (m_losses == LIMIT));
      e_gi     = idle && ifu_wins;
      e_gl     = idle && lsu_req_valid && !ifu_wins;

      checkOutput("ifu_req_ready", 32'(ifu_req_ready), 32'(e_gi));
      checkOutput("lsu_req_ready", 32'(lsu_req_ready), 32'(e_gl));
      checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(m_busy && !m_issued));
      if (m_busy && !m_issued) begin
         checkOutput("mem_addr", mem_addr, m_addr);
         checkOutput("mem_wen", 32'(mem_wen), 32'(m_wen));
         checkOutput("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
         if (m_own_lsu) checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      checkOutput("ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_pulse_ifu));
      checkOutput("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_pulse_lsu));
      if (m_pulse_ifu) checkOutput("ifu_rdata", ifu_rdata, m_ifu_rdata);
      if (m_pulse_lsu) checkOutput("lsu_rdata", lsu_rdata, m_lsu_rdata);
      if ((m_pulse_ifu || m_pulse_lsu) && chk_latency)
         checkOutput("accept_to_pulse", 32'(cycle - acc_cycle), 32'd3);
      if (!rst) begin
         if (ifu_req_ready) grant_log.push_back(1'b0);
         if (lsu_req_ready) grant_log.push_back(1'b1);
      end

      if (rst) begin
         m_busy      = 1'b0;
         m_issued    = 1'b0;
         m_pulse_ifu = 1'b0;
         m_pulse_lsu = 1'b0;
         m_losses    = 0;
      end else begin
         m_pulse_ifu = 1'b0;
         m_pulse_lsu = 1'b0;
         if (m_busy && m_issued && mem_resp_valid) begin
            m_busy = 1'b0;
            if (m_own_lsu) begin
               m_pulse_lsu = 1'b1;
               m_lsu_rdata = m_wen ? 32'd0 : mem_rdata;
            end else begin
               m_pulse_ifu = 1'b1;
               m_ifu_rdata = mem_rdata;
            end
         end else if (m_busy && !m_issued) begin
            if (mem_req_ready) m_issued = 1'b1;
            else               issue_wait++;
         end
         if (e_gi || e_gl) begin
            if (chk_gap && (prev_acc_cycle >= 0))
               checkOutput("accept_gap", 32'(cycle - prev_acc_cycle), 32'd3);
            prev_acc_cycle = cycle;
            acc_cycle      = cycle;
            m_busy         = 1'b1;
            m_issued       = 1'b0;
            issue_wait     = 0;
            m_own_lsu      = e_gl;
            if (e_gi) begin
               m_wen    = 1'b0;
               m_addr   = ifu_addr;
               m_wdata  = 32'd0;
               m_wmask  = 4'd0;
               m_losses = 0;
               if (ifu_pend > 0) begin
                  ifu_pend--;
                  ifu_next_addr += 32'd4;
               end
            end else begin
               m_wen   = lsu_wen;
               m_addr  = lsu_addr;
               m_wdata = lsu_wdata;
               m_wmask = lsu_wmask;
               if (ifu_req_valid && (m_losses < LIMIT)) m_losses++;
               if (lsu_pend > 0) begin
                  lsu_pend--;
                  lsu_next_addr += 32'd4;
               end
            end
         end
      end

      @(posedge sys_clk);
      #1;
      cycle++;
   endtask

   initial begin
      sys_rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      m_busy = 0; m_issued = 0; m_own_lsu = 0; m_wen = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
      m_losses = 0; m_pulse_ifu = 0; m_pulse_lsu = 0; m_ifu_rdata = '0; m_lsu_rdata = '0;
      acc_cycle = 0; prev_acc_cycle = -1; issue_wait = 0;
      req_random = 0; mem_random = 0; hold_resp = 0; stray_resp = 0; chk_latency = 1; chk_gap = 0;
      mem_fixed_en = 0; mem_fixed_data = '0; ifu_pend = 0; lsu_pend = 0; ready_delay = 0;
      ifu_next_addr = '0; lsu_next_addr = '0; lsu_next_wdata = '0; lsu_next_wen = 0; lsu_next_wmask = '0;

      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      #1;
      checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      checkOutput("rst_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
      checkOutput("rst_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
      checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
      checkOutput("rst_ifu_rdata", ifu_rdata, 32'd0);
      checkOutput("rst_lsu_rdata", lsu_rdata, 32'd0);
      checkOutput("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
      checkOutput("rst_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
      @(posedge sys_clk);
      #1;

      $display("[TB] IFU-only fetch");
      mem_fixed_en = 1; mem_fixed_data = 32'h0000_0413;
      ifu_next_addr = 32'h8000_0000; ifu_pend = 1;
      repeat (6) applyStimulus(0);
      checkOutput("ifu_fetch_data", ifu_rdata, 32'h0000_0413);
      mem_fixed_en = 0;

      $display("[TB] Simultaneous requests");
      grant_log.delete();
      ifu_next_addr = 32'h8000_0010; ifu_pend = 1;
      lsu_next_wen = 0; lsu_next_addr = 32'h8000_0100; lsu_next_wdata = '0; lsu_next_wmask = '0; lsu_pend = 1;
      repeat (10) applyStimulus(0);
      checkOutput("simul_grant_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() >= 2) begin
         checkOutput("simul_first_lsu", 32'(grant_log[0]), 32'd1);
         checkOutput("simul_then_ifu", 32'(grant_log[1]), 32'd0);
      end

      $display("[TB] Starvation pattern");
      grant_log.delete();
      ifu_pend = 100; lsu_pend = 100;
      for (int n = 0; (n < 200) && (grant_log.size() < 10); n++) applyStimulus(0);
      checkOutput("starve_grant_count", 32'(grant_log.size() >= 10), 32'd1);
      for (int i = 0; (i < 10) && (i < grant_log.size()); i++) begin
         bit exp_lsu;
         exp_lsu = ((i % 5) != 4);
         checkOutput($sformatf("starve_grant_%0d", i), 32'(grant_log[i]), 32'(exp_lsu));
      end
      ifu_pend = 0; lsu_pend = 0;
      repeat (6) applyStimulus(0);

      $display("[TB] Store with delayed memory ready");
      chk_latency = 0; ready_delay = 3;
      lsu_next_wen = 1; lsu_next_addr = 32'h8000_0200; lsu_next_wdata = 32'hDEAD_BEEF;
      lsu_next_wmask = 4'b0011; lsu_pend = 1;
      repeat (12) applyStimulus(0);
      checkOutput("store_lsu_rdata", lsu_rdata, 32'd0);
      lsu_next_wen = 0; ready_delay = 0; chk_latency = 1;

      $display("[TB] Reset during WAIT");
      hold_resp = 1; ifu_next_addr = 32'h8000_0040; ifu_pend = 1;
      repeat (3) applyStimulus(0);
      applyStimulus(1);
      stray_resp = 1;
      applyStimulus(0);
      stray_resp = 0; hold_resp = 0;
      checkOutput("post_reset_no_pulse", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
      ifu_pend = 1;
      repeat (6) applyStimulus(0);

      $display("[TB] Back-to-back fetches");
      chk_gap = 1; prev_acc_cycle = -1; ifu_next_addr = 32'h8000_1000; ifu_pend = 4;
      repeat (16) applyStimulus(0);
      chk_gap = 0;

      $display("[TB] Randomized traffic");
      chk_latency = 0; req_random = 1; mem_random = 1;
      for (int n = 0; n < 600; n++) applyStimulus($urandom_range(0, 99) == 0);
      req_random = 0; mem_random = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
